// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : arbiter FSM states (idle / response pending)
//   F3_*        : funct3 access-type encodings seen on the memory port
//   is_legal()  : access check on (we, funct3, addr[1:0]); returns 1 when the
//                 access must be rejected (the error flag), 0 when it may proceed
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StResp = 1'b1
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Returns the error flag: 1 for an unsupported funct3 or a misaligned address.
  function automatic logic is_legal(input logic       we,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    bad_f3     = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = we;  // unsigned variants only exist for loads
      default:          bad_f3 = 1'b1;
    endcase
    // funct3[1:0] encodes the access size for every legal code
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
    return bad_f3 | misaligned;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   rr_i      : index that has highest priority this cycle
//   gnt_o     : one-hot grant (zero when no request)
//   gnt_idx_o : index of the granted requester
//   any_o     : a grant was made
module dmem_rr_arb #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan NREQ positions starting at rr_i; the first set request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_i} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NREQ)) begin
        sum = sum - (IDX_W + 1)'(NREQ);
      end
      idx = sum[IDX_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter / sequencer sharing one byte-addressed data memory
// between NREQ requesters.
//   i_req_*   : per-requester request (valid, addr, wdata, we, funct3)
//   o_req_ready : one-hot accept, only in the idle state
//   o_rsp_*   : registered response to the owner, held until i_rsp_ready
//   o_mem_*   : memory port, driven from the granted requester, zero otherwise
//   i_mem_q   : combinational memory read data (already extended by memory)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [NREQ-1:0]              i_req_valid,
  output logic [NREQ-1:0]              o_req_ready,
  input  logic [NREQ-1:0][ADDR_W-1:0]  i_req_addr,
  input  logic [NREQ-1:0][31:0]        i_req_wdata,
  input  logic [NREQ-1:0]              i_req_we,
  input  logic [NREQ-1:0][2:0]         i_req_funct3,
  output logic [NREQ-1:0]              o_rsp_valid,
  input  logic [NREQ-1:0]              i_rsp_ready,
  output logic [31:0]                  o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [31:0]                  o_mem_wdata,
  output logic                         o_mem_wren,
  output logic [2:0]                   o_mem_funct3,
  input  logic [31:0]                  i_mem_q
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              gnt_any;

  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_we;
  logic [2:0]        sel_funct3;
  logic              acc_err;

  // Requests are only arbitrated in idle, and never while reset is held so the
  // memory port stays quiet during reset.
  assign arb_req = (state_q == StIdle && i_reset) ? i_req_valid : '0;

  dmem_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IdxW)
  ) u_rr_arb (
    .req_i     (arb_req),
    .rr_i      (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    sel_addr   = i_req_addr[gnt_idx];
    sel_wdata  = i_req_wdata[gnt_idx];
    sel_we     = i_req_we[gnt_idx];
    sel_funct3 = i_req_funct3[gnt_idx];
    acc_err    = is_legal(sel_we, sel_funct3, sel_addr[1:0]);

    o_req_ready  = gnt;
    o_mem_addr   = gnt_any ? sel_addr : '0;
    o_mem_wdata  = gnt_any ? sel_wdata : '0;
    o_mem_funct3 = gnt_any ? sel_funct3 : '0;
    o_mem_wren   = gnt_any & sel_we & ~acc_err;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    o_rsp_valid = '0;
    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          state_d = StResp;
          owner_d = gnt_idx;
          rr_d    = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          // Stores and rejected accesses return zero data.
          rdata_d = (sel_we || acc_err) ? '0 : i_mem_q;
          err_d   = acc_err;
        end
      end
      StResp: begin
        o_rsp_valid[owner_q] = 1'b1;
        if (i_rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule
